// File: rtl/mem_op_issue_queue.sv
// Memory-op issue queue: buffers ops from execute and feeds them one at a time to the TLB/dcache FSM.
// Optional MEMQ_TIMEOUT_EN adds a watchdog (TIMEOUT_CYCLES, err_timeout_o) on the wait states.
module mem_op_issue_queue #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned ADDR_W         = 40,
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TAG_W          = 5,
`ifdef MEMQ_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 256,
`endif
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic                     enq_is_store_i,
  input  logic [ADDR_W-1:0]        enq_addr_i,
  input  logic [DATA_W-1:0]        enq_data_i,
  input  logic [1:0]               enq_size_i,
  input  logic [TAG_W-1:0]         enq_tag_i,
  input  logic                     flush_i,
  output logic                     is_load_o,
  output logic                     is_store_o,
  output logic [ADDR_W-1:0]        op_addr_o,
  output logic [DATA_W-1:0]        op_data_o,
  output logic [1:0]               op_size_o,
  output logic [TAG_W-1:0]         op_tag_o,
  input  logic                     st_done_i,
  input  logic                     ld_resp_valid_i,
  output logic                     kill_mem_op_o,
  output logic                     cmpl_valid_o,
  output logic [TAG_W-1:0]         cmpl_tag_o,
  output logic                     cmpl_is_store_o,
`ifdef MEMQ_TIMEOUT_EN
  output logic                     err_timeout_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StFlushWait, StGap} state_e;

  state_e             state;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               mem_store [DEPTH];
  logic [ADDR_W-1:0]  mem_addr  [DEPTH];
  logic [DATA_W-1:0]  mem_data  [DEPTH];
  logic [1:0]         mem_size  [DEPTH];
  logic [TAG_W-1:0]   mem_tag   [DEPTH];
  logic               cur_store;
  logic               st_done_prev;
  logic [GAP_W-1:0]   gap_cnt;
  logic               push, pop, done, timeout;

  assign count_o     = count;
  assign enq_ready_o = (count != CNT_W'(DEPTH));
  assign push        = enq_valid_i & enq_ready_o & ~flush_i;
  // A store completes only on the rising edge of the level-style st_done_i.
  assign done        = cur_store ? (st_done_i & ~st_done_prev) : ld_resp_valid_i;
  assign pop         = (state == StWait) & ~flush_i & (done | timeout);

`ifdef MEMQ_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        in_wait;

  assign in_wait = (state == StWait) | (state == StFlushWait);
  assign timeout = in_wait & ~flush_i & ~done & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt       <= '0;
      err_timeout_o <= 1'b0;
    end else begin
      tmo_cnt       <= in_wait ? tmo_cnt + 16'd1 : '0;
      err_timeout_o <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem_store[wr_ptr] <= enq_is_store_i;
      mem_addr[wr_ptr]  <= enq_addr_i;
      mem_data[wr_ptr]  <= enq_data_i;
      mem_size[wr_ptr]  <= enq_size_i;
      mem_tag[wr_ptr]   <= enq_tag_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= StIdle;
      is_load_o       <= 1'b0;
      is_store_o      <= 1'b0;
      op_addr_o       <= '0;
      op_data_o       <= '0;
      op_size_o       <= '0;
      op_tag_o        <= '0;
      kill_mem_op_o   <= 1'b0;
      cmpl_valid_o    <= 1'b0;
      cmpl_tag_o      <= '0;
      cmpl_is_store_o <= 1'b0;
      cur_store       <= 1'b0;
      st_done_prev    <= 1'b0;
      gap_cnt         <= '0;
    end else begin
      is_load_o     <= 1'b0;
      is_store_o    <= 1'b0;
      cmpl_valid_o  <= 1'b0;
      kill_mem_op_o <= 1'b0;
      st_done_prev  <= st_done_i;
      case (state)
        StIdle: begin
          if (flush_i) begin
            kill_mem_op_o <= 1'b1;
          end else if (count != '0) begin
            state      <= StIssue;
            is_load_o  <= ~mem_store[rd_ptr];
            is_store_o <= mem_store[rd_ptr];
            cur_store  <= mem_store[rd_ptr];
            op_addr_o  <= mem_addr[rd_ptr];
            op_data_o  <= mem_data[rd_ptr];
            op_size_o  <= mem_size[rd_ptr];
            op_tag_o   <= mem_tag[rd_ptr];
          end
        end
        StIssue: begin
          if (flush_i) begin
            state         <= StFlushWait;
            kill_mem_op_o <= 1'b1;
          end else begin
            state <= StWait;
          end
        end
        StWait: begin
          if (flush_i) begin
            state         <= StFlushWait;
            kill_mem_op_o <= 1'b1;
          end else if (done) begin
            state           <= StGap;
            gap_cnt         <= GAP_W'(GAP_CYCLES - 1);
            cmpl_valid_o    <= 1'b1;
            cmpl_tag_o      <= op_tag_o;
            cmpl_is_store_o <= cur_store;
          end else if (timeout) begin
            state         <= StGap;
            gap_cnt       <= GAP_W'(GAP_CYCLES - 1);
            kill_mem_op_o <= 1'b1;
          end
        end
        StFlushWait: begin
          // The op in flight was flushed: its completion only releases the FSM.
          if (!flush_i && (done || timeout)) begin
            state         <= StGap;
            gap_cnt       <= GAP_W'(GAP_CYCLES - 1);
            kill_mem_op_o <= timeout;
          end else begin
            kill_mem_op_o <= 1'b1;
          end
        end
        StGap: begin
          kill_mem_op_o <= flush_i;
          if (gap_cnt == '0) state <= StIdle;
          else               gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_op_issue_queue.sv
// Directed bench for mem_op_issue_queue: issue latency, retire, gap, full FIFO, wrap, flushes.
// The watchdog case runs only when MEMQ_TIMEOUT_EN is defined.
module tb_mem_op_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_ready, enq_is_store;
  logic [39:0] enq_addr;
  logic [63:0] enq_data;
  logic [1:0]  enq_size;
  logic [4:0]  enq_tag;
  logic        flush;
  logic        is_load, is_store;
  logic [39:0] op_addr;
  logic [63:0] op_data;
  logic [1:0]  op_size;
  logic [4:0]  op_tag;
  logic        st_done, ld_resp;
  logic        kill;
  logic        cmpl_valid;
  logic [4:0]  cmpl_tag;
  logic        cmpl_is_store;
  logic [2:0]  count;
`ifdef MEMQ_TIMEOUT_EN
  logic        err_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_op_issue_queue #(
`ifdef MEMQ_TIMEOUT_EN
    .TIMEOUT_CYCLES(16),
`endif
    .DEPTH(4),
    .ADDR_W(40),
    .DATA_W(64),
    .TAG_W(5),
    .GAP_CYCLES(2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enq_valid_i     (enq_valid),
    .enq_ready_o     (enq_ready),
    .enq_is_store_i  (enq_is_store),
    .enq_addr_i      (enq_addr),
    .enq_data_i      (enq_data),
    .enq_size_i      (enq_size),
    .enq_tag_i       (enq_tag),
    .flush_i         (flush),
    .is_load_o       (is_load),
    .is_store_o      (is_store),
    .op_addr_o       (op_addr),
    .op_data_o       (op_data),
    .op_size_o       (op_size),
    .op_tag_o        (op_tag),
    .st_done_i       (st_done),
    .ld_resp_valid_i (ld_resp),
    .kill_mem_op_o   (kill),
    .cmpl_valid_o    (cmpl_valid),
    .cmpl_tag_o      (cmpl_tag),
    .cmpl_is_store_o (cmpl_is_store),
`ifdef MEMQ_TIMEOUT_EN
    .err_timeout_o   (err_timeout),
`endif
    .count_o         (count)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Presents one op for one cycle, starting at the current negedge.
  task automatic enq_op(input logic st, input logic [39:0] a, input logic [63:0] d,
                        input logic [1:0] sz, input logic [4:0] tg);
    enq_valid    = 1'b1;
    enq_is_store = st;
    enq_addr     = a;
    enq_data     = d;
    enq_size     = sz;
    enq_tag      = tg;
    step();
    enq_valid    = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (!(is_load | is_store) && n < 20) begin
      step();
      n++;
    end
    check_eq(tag, is_load | is_store, 1);
  endtask

  // From an issue cycle: answer the load one cycle later, then check the retire pulse.
  task automatic serve_load(input string tag, input logic [4:0] tg);
    step();
    ld_resp = 1'b1;
    step();
    ld_resp = 1'b0;
    check_eq(tag, {cmpl_valid, cmpl_is_store, cmpl_tag}, {1'b1, 1'b0, tg});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim did not finish");
    $fatal(1);
  end

  initial begin
    int cmpl_seen;
    int nxt;
    logic kill_all, cmpl_any, issue_any;

    rst = 1'b0; enq_valid = 1'b0; enq_is_store = 1'b0; enq_addr = '0; enq_data = '0;
    enq_size = '0; enq_tag = '0; flush = 1'b0; st_done = 1'b0; ld_resp = 1'b0;
    step(2);
    rst = 1'b1;
    step();

    check_eq("rst_count", count, 0);
    check_eq("rst_ready", enq_ready, 1);
    check_eq("rst_outs", {is_load, is_store, kill, cmpl_valid, cmpl_tag, op_addr}, 0);

    // T1: single load
    enq_op(1'b0, 40'h1000, 64'h0, 2'd3, 5'd3);
    check_eq("t1_count1", count, 1);
    check_eq("t1_no_early_issue", is_load, 0);
    step();
    check_eq("t1_is_load", {is_load, is_store}, 2'b10);
    check_eq("t1_op_addr", op_addr, 40'h1000);
    check_eq("t1_op_tag", op_tag, 3);
    step();
    check_eq("t1_pulse_one_cycle", is_load, 0);
    check_eq("t1_addr_held", op_addr, 40'h1000);
    step(2);
    check_eq("t1_no_cmpl_yet", cmpl_valid, 0);
    ld_resp = 1'b1;
    step();
    ld_resp = 1'b0;
    check_eq("t1_cmpl", {cmpl_valid, cmpl_is_store, cmpl_tag}, {1'b1, 1'b0, 5'd3});
    check_eq("t1_count0", count, 0);
    step();
    check_eq("t1_cmpl_one_cycle", cmpl_valid, 0);
    step(4);

    // T2: store with level st_done, then gap before the next op
    enq_op(1'b1, 40'h2000, 64'hDEAD_BEEF_0000_0007, 2'd3, 5'd7);
    step();
    check_eq("t2_is_store", {is_load, is_store}, 2'b01);
    check_eq("t2_op_data", op_data, 64'hDEAD_BEEF_0000_0007);
    enq_op(1'b0, 40'h3000, 64'h0, 2'd2, 5'd9);
    check_eq("t2_count2", count, 2);
    st_done = 1'b1;
    step();
    cmpl_seen = int'(cmpl_valid);
    check_eq("t2_cmpl", {cmpl_is_store, cmpl_tag}, {1'b1, 5'd7});
    check_eq("t2_count1", count, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      cmpl_seen += int'(cmpl_valid);
      if (i < 2) check_eq("t2_gap_no_issue", is_load, 0);
    end
    st_done = 1'b0;
    check_eq("t2_single_cmpl", cmpl_seen, 1);
    check_eq("t2_issue_after_gap", is_load, 1);
    check_eq("t2_next_tag", op_tag, 9);
    check_eq("t2_next_size", op_size, 2);
    serve_load("t2_cmpl_load", 5'd9);
    step(4);

    // T3: fill, overflow attempt, FIFO order across wrap
    for (int t = 10; t < 14; t++) enq_op(1'b0, 40'(t) << 8, 64'h0, 2'd0, 5'(t));
    check_eq("t3_count_full", count, 4);
    check_eq("t3_not_ready", enq_ready, 0);
    enq_valid = 1'b1; enq_tag = 5'd30;
    step();
    enq_valid = 1'b0;
    check_eq("t3_overflow_ignored", count, 4);
    ld_resp = 1'b1;
    step();
    ld_resp = 1'b0;
    check_eq("t3_cmpl_first", {cmpl_valid, cmpl_tag}, {1'b1, 5'd10});
    check_eq("t3_count3", count, 3);
    check_eq("t3_ready_again", enq_ready, 1);
    enq_op(1'b0, 40'(14) << 8, 64'h0, 2'd0, 5'd14);
    nxt = 15;
    for (int k = 11; k < 18; k++) begin
      wait_issue("t3_issue");
      check_eq("t3_order_tag", op_tag, 64'(k));
      check_eq("t3_order_addr", op_addr, 64'(k) << 8);
      serve_load("t3_cmpl", 5'(k));
      if (nxt < 18) begin
        enq_op(1'b0, 40'(nxt) << 8, 64'h0, 2'd0, 5'(nxt));
        nxt++;
      end
    end
    check_eq("t3_drained", count, 0);
    step(4);

    // T4: flush during WAIT of a load with three more queued
    enq_op(1'b0, 40'h4000, 64'h0, 2'd3, 5'd2);
    for (int t = 20; t < 23; t++) enq_op(1'b0, 40'h5000, 64'h0, 2'd3, 5'(t));
    check_eq("t4_count4", count, 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("t4_count_cleared", count, 0);
    check_eq("t4_kill", kill, 1);
    kill_all = 1'b1; cmpl_any = 1'b0; issue_any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      kill_all &= kill; cmpl_any |= cmpl_valid; issue_any |= is_load | is_store;
    end
    check_eq("t4_kill_held", kill_all, 1);
    ld_resp = 1'b1;
    step();
    ld_resp = 1'b0;
    check_eq("t4_kill_released", kill, 0);
    cmpl_any |= cmpl_valid;
    check_eq("t4_no_cmpl", cmpl_any, 0);
    step(3);
    check_eq("t4_no_issue", issue_any | is_load | is_store, 0);
    enq_op(1'b0, 40'h6000, 64'h0, 2'd1, 5'd23);
    step();
    check_eq("t4_back_to_idle", {is_load, op_tag}, {1'b1, 5'd23});
    serve_load("t4_cmpl_after", 5'd23);
    step(4);

    // T5: flush and enqueue together in IDLE
    enq_valid = 1'b1; enq_is_store = 1'b0; enq_tag = 5'd24; flush = 1'b1;
    step();
    enq_valid = 1'b0; flush = 1'b0;
    check_eq("t5_count0", count, 0);
    check_eq("t5_kill_pulse", kill, 1);
    step();
    check_eq("t5_kill_one_cycle", kill, 0);
    issue_any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      issue_any |= is_load | is_store;
    end
    check_eq("t5_entry_dropped", issue_any, 0);

`ifdef MEMQ_TIMEOUT_EN
    // T6: store never completes, watchdog retires it
    enq_op(1'b1, 40'h7000, 64'h1234, 2'd3, 5'd25);
    step();
    check_eq("t6_is_store", is_store, 1);
    enq_op(1'b0, 40'h8000, 64'h0, 2'd3, 5'd26);
    cmpl_any = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      step();
      cmpl_any |= err_timeout;
    end
    check_eq("t6_no_early_err", cmpl_any, 0);
    step();
    check_eq("t6_err_pulse", {err_timeout, kill, cmpl_valid}, 3'b110);
    check_eq("t6_head_popped", count, 1);
    step();
    check_eq("t6_err_one_cycle", {err_timeout, kill, is_load}, 3'b000);
    step(2);
    check_eq("t6_next_issue", {is_load, op_tag}, {1'b1, 5'd26});
    serve_load("t6_cmpl_next", 5'd26);
    step(4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
